// File: rtl/alk_pkg.sv
// Shared encodings for the DC615 ALK multiply/divide sequencer.
package alk_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_DIV  = 2'd1,
        OP_REM  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        DSIZE_BYTE = 2'd0,
        DSIZE_WORD = 2'd1,
        DSIZE_LONG = 2'd2,
        DSIZE_RSVD = 2'd3
    } dsize_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ITER  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [9:0] ALPCTL_NOP      = 10'h000;
    localparam logic [9:0] ALPCTL_MULINIT  = 10'h040;
    localparam logic [9:0] ALPCTL_MULSTEP  = 10'h041;
    localparam logic [9:0] ALPCTL_MULSTEP2 = 10'h049;
    localparam logic [9:0] ALPCTL_DIVINIT  = 10'h050;
    localparam logic [9:0] ALPCTL_DIVSTEP  = 10'h051;
    localparam logic [9:0] ALPCTL_DIVSTEP2 = 10'h059;
    localparam logic [9:0] ALPCTL_DIVFIX   = 10'h052;
    localparam logic [9:0] ALPCTL_REMFIX   = 10'h053;

    localparam logic [2:0] ALUSHF_SHF = 3'b001;

    // Bit count of an operand; the reserved size is handled as long.
    function automatic logic [5:0] iter_count(input logic [1:0] dsize);
        case (dsize)
            DSIZE_BYTE: iter_count = 6'd8;
            DSIZE_WORD: iter_count = 6'd16;
            default:    iter_count = 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/alk_iter_cnt.sv
// Loadable iteration down-counter with size decode and terminal-count flag.
// ALK_DBLCLK_EN: load half the bit count (two iterations per cycle).
module alk_iter_cnt
    import alk_pkg::*;
#(
    parameter int unsigned ITER_W = 6
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [1:0]        dsize,
    input  logic              dec,
    input  logic              clr,
    output logic [ITER_W-1:0] count,
    output logic              tc
);

    logic [ITER_W-1:0] count_q, count_d;
    logic [ITER_W-1:0] load_val;

    always_comb begin
        load_val = ITER_W'(iter_count(dsize));
`ifdef ALK_DBLCLK_EN
        load_val = load_val >> 1;
`endif
    end

    // Saturates at zero so a stray decrement can never wrap.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - ITER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == ITER_W'(1));

endmodule

// File: rtl/alk_muldiv_seq.sv
// Multi-cycle MUL/DIV/REM sequencer driving the ALK control fields.
// ALK_DBLCLK_EN: issue *STEP2 opcodes, two iterations per cycle.
module alk_muldiv_seq
    import alk_pkg::*;
#(
    parameter int unsigned ITER_W           = 6,
    parameter bit          FIXUP_EN_DEFAULT = 1'b1
)(
    input  logic              qdck_l,
    input  logic              reset_h,
    input  logic              start_h,
    input  logic [1:0]        op_h,
    input  logic [1:0]        dsize_in_h,
    input  logic              abort_h,
    input  logic              loop_flag_h,
    output logic [9:0]        alpctl_h,
    output logic [5:0]        rot_h,
    output logic [1:0]        dsize_h,
    output logic              busy_h,
    output logic              done_h,
    output logic              stall_l,
    output logic [ITER_W-1:0] iter_h,
    output logic              dzero_h
);

`ifdef ALK_DBLCLK_EN
    localparam logic [9:0] MUL_STEP_OP = ALPCTL_MULSTEP2;
    localparam logic [9:0] DIV_STEP_OP = ALPCTL_DIVSTEP2;
`else
    localparam logic [9:0] MUL_STEP_OP = ALPCTL_MULSTEP;
    localparam logic [9:0] DIV_STEP_OP = ALPCTL_DIVSTEP;
`endif

    state_e     state_q, state_d;
    op_e        op_q, op_d;
    logic [1:0] dsize_q, dsize_d;
    logic       first_q, first_d;
    logic       dzero_q, dzero_d;
    logic       fixup_en_q, fixup_en_d;
    logic [9:0] alpctl_q, alpctl_d;
    logic [5:0] rot_q, rot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic              kill;
    logic              accept;
    logic              dz_hit;
    logic              cnt_dec;
    logic              cnt_tc;
    logic [ITER_W-1:0] cnt_val;

    // Holding off while done_h is showing keeps a start in the done cycle from being taken.
    assign kill    = abort_h && (state_q != IDLE);
    assign accept  = (state_q == IDLE) && start_h && !abort_h && !done_q && (op_h != OP_RSVD);
    assign dz_hit  = (state_q == ITER) && first_q && loop_flag_h && (op_q != OP_MUL);
    assign cnt_dec = (state_q == ITER) && !kill;

    alk_iter_cnt #(
        .ITER_W(ITER_W)
    ) u_iter_cnt (
        .clk   (qdck_l),
        .rst   (reset_h),
        .load  (accept),
        .dsize (dsize_in_h),
        .dec   (cnt_dec),
        .clr   (kill),
        .count (cnt_val),
        .tc    (cnt_tc)
    );

    always_ff @(posedge qdck_l) begin
        if (reset_h) begin
            state_q    <= IDLE;
            op_q       <= OP_MUL;
            dsize_q    <= '0;
            first_q    <= 1'b0;
            dzero_q    <= 1'b0;
            fixup_en_q <= FIXUP_EN_DEFAULT;
            alpctl_q   <= ALPCTL_NOP;
            rot_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dsize_q    <= dsize_d;
            first_q    <= first_d;
            dzero_q    <= dzero_d;
            fixup_en_q <= fixup_en_d;
            alpctl_q   <= alpctl_d;
            rot_q      <= rot_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = SETUP;
                SETUP:   state_d = ITER;
                ITER: begin
                    if (dz_hit) begin
                        state_d = DONE;
                    end else if (cnt_tc) begin
                        state_d = ((op_q == OP_MUL) || !fixup_en_q) ? DONE : FIXUP;
                    end
                end
                FIXUP:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        op_d       = op_q;
        dsize_d    = dsize_q;
        dzero_d    = dzero_q;
        fixup_en_d = fixup_en_q;
        first_d    = (state_q == SETUP) && !kill;
        if (accept) begin
            op_d    = op_e'(op_h);
            dsize_d = (dsize_in_h == DSIZE_RSVD) ? DSIZE_LONG : dsize_in_h;
            dzero_d = 1'b0;
        end else if (dz_hit && !kill) begin
            dzero_d = 1'b1;
        end
    end

    // Control fields follow the state one edge later; abort clears them immediately.
    always_comb begin
        alpctl_d = ALPCTL_NOP;
        rot_d    = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        if (!kill) begin
            case (state_q)
                SETUP: begin
                    alpctl_d = (op_q == OP_MUL) ? ALPCTL_MULINIT : ALPCTL_DIVINIT;
                    rot_d    = {1'b0, ALUSHF_SHF, 2'b00};
                    busy_d   = 1'b1;
                end
                ITER: begin
                    alpctl_d = (op_q == OP_MUL) ? MUL_STEP_OP : DIV_STEP_OP;
                    busy_d   = 1'b1;
                end
                FIXUP: begin
                    alpctl_d = (op_q == OP_REM) ? ALPCTL_REMFIX : ALPCTL_DIVFIX;
                    rot_d    = {1'b0, 3'b000, 2'b01};
                    busy_d   = 1'b1;
                end
                DONE:    done_d = 1'b1;
                default: ;
            endcase
        end
    end

    assign alpctl_h = alpctl_q;
    assign rot_h    = rot_q;
    assign dsize_h  = dsize_q;
    assign busy_h   = busy_q;
    assign done_h   = done_q;
    assign stall_l  = ~busy_q;
    assign iter_h   = cnt_val;
    assign dzero_h  = dzero_q;

endmodule

// File: doc/alk_muldiv_seq.md
Name: alk_muldiv_seq

Overview:
- Sequencer that runs a multi-cycle multiply, divide or remainder on the DC615 ALK/ALP slice pair, one iteration per qdck_l cycle.
- Accepts a one-cycle start request from the microsequencer and drives the ALK control fields alpctl_h, rot_h and dsize_h.
- Counts iterations by data size, then issues a fixup step for divide/remainder, and reports done and the loop flag.
- Sits between the microsequencer stall logic and the ALK control inputs.

Parameters:
- ITER_W, 6, width of the iteration counter (covers 0..32).
- FIXUP_EN_DEFAULT, 1, reset value of the fixup-enable bit for divide/remainder.

Ports:
- qdck_l  input  1  clock; all registers update on its rising edge.
- reset_h  input  1  synchronous active-high reset.
- start_h  input  1  start request; sampled only in IDLE.
- op_h  input  2  operation: 0 = MUL, 1 = DIV, 2 = REM, 3 = reserved (ignored).
- dsize_in_h  input  2  operand size: 0 = byte, 1 = word, 2 = long, 3 = reserved (treated as long).
- abort_h  input  1  microtrap kill; has priority over everything except reset.
- loop_flag_h  input  1  ALK loop flag, fed back from wbus_h_out[31].
- alpctl_h  output  10  ALK opcode field.
- rot_h  output  6  ALK ROT field; ALUSHF in [4:2], ALUCI in [1:0].
- dsize_h  output  2  latched operand size, driven to the ALK.
- busy_h  output  1  high from the cycle after start acceptance until done.
- done_h  output  1  one-cycle pulse when the result is valid.
- stall_l  output  1  low while busy, to stall the microsequencer.
- iter_h  output  ITER_W  iterations remaining.
- dzero_h  output  1  latched divide-by-zero indication.

Behaviour:
- Reset values: alpctl_h = ALPCTL_NOP, rot_h = 0, dsize_h = 0, busy_h = 0, done_h = 0, stall_l = 1, iter_h = 0, dzero_h = 0; state = IDLE.
- State IDLE:
  - On start_h with op_h != 3, latch op_h and dsize_in_h, load iter with N (byte 8, word 16, long 32), clear dzero_h, and go to SETUP.
  - A start_h with op_h = 3 is ignored.
- State SETUP (1 cycle):
  - Drive the op's init opcode (MULINIT/DIVINIT) with ALUSHF = SHF and ALUCI = 0.
  - Go to ITER.
- State ITER:
  - Each cycle drive the op's step opcode (MULSTEP/DIVSTEP) and decrement iter.
  - DIV/REM: if loop_flag_h = 1 on the first ITER cycle, set dzero_h and go straight to DONE.
  - When iter reaches 1: MUL goes to DONE; DIV/REM go to FIXUP.
  - ITER always lasts exactly N cycles unless aborted or dzero.
- State FIXUP (1 cycle): drive DIVFIX (for REM, REMFIX) with ALUCI = 1; go to DONE.
- State DONE (1 cycle): done_h = 1, alpctl_h = ALPCTL_NOP; return to IDLE.
- busy_h and stall_l:
  - busy_h is high in SETUP, ITER and FIXUP.
  - stall_l is the inverse of busy_h.
  - done_h never overlaps busy_h.
- Total latency from start acceptance to done_h:
  - MUL: N+2 cycles.
  - DIV/REM: N+3 cycles.
  - dzero case: 3 cycles.
- Abort: abort_h in any non-IDLE state returns to IDLE next cycle, drives ALPCTL_NOP, clears iter, and suppresses done_h.
- Simultaneous events:
  - start_h while busy is ignored (no queueing).
  - start_h in the same cycle as DONE is ignored.
  - abort_h together with start_h in IDLE: start is discarded.
- Reset mid-operation: immediate return to the reset values at the next edge.
- Outputs are registered: opcode changes take effect one edge after the state transition.
- iter never wraps below 0.

Optional Feature:
- Macro: ALK_DBLCLK_EN.
- Defined:
  - ITER drives the *STEP2 opcodes, which assert the ALK dbl_h path and perform 2 iterations per cycle.
  - iter loads N/2 and decrements by 1.
  - MUL latency becomes N/2+2; DIV/REM latency becomes N/2+3.
- Undefined: one iteration per cycle, as above; the *STEP2 constants are unused.

Decomposition:
- Package alk_pkg holds:
  - the op_h and dsize encodings;
  - state enum IDLE/SETUP/ITER/FIXUP/DONE;
  - ALPCTL constants: NOP = 10'h000, MULINIT = 10'h040, MULSTEP = 10'h041, MULSTEP2 = 10'h049, DIVINIT = 10'h050, DIVSTEP = 10'h051, DIVSTEP2 = 10'h059, DIVFIX = 10'h052, REMFIX = 10'h053;
  - ALUSHF code SHF = 3'b001.
- One sub-module, alk_iter_cnt: a loadable down-counter with size decode and a terminal-count flag.

Test Plan:
- MUL long: start_h with op 0, dsize 2 -> SETUP 1 cycle, 32 MULSTEP cycles, done_h on cycle 34; busy_h high for exactly 33 cycles.
- DIV word: op 1, dsize 1 -> 16 DIVSTEP cycles then 1 DIVFIX cycle (ALUCI = 1); done_h on cycle 19; dzero_h = 0.
- Divide by zero: op 2, dsize 0, loop_flag_h = 1 on the first ITER cycle -> dzero_h = 1, done_h 3 cycles after acceptance, no REMFIX issued.
- Abort: abort_h at ITER with iter = 10 -> next cycle IDLE, alpctl_h = 10'h000, iter_h = 0, busy_h = 0, no done_h.
- Reset and ignored starts: reset_h during FIXUP -> all outputs at reset values; start_h while busy, and start_h with op 3 -> ignored.
- With ALK_DBLCLK_EN, MUL long -> 16 MULSTEP2 cycles, done_h on cycle 18.
